// File: rtl/receptor_medida_serial_pkg.sv
// Shared encodings and ASCII constants for the serial measurement receiver.
package receptor_medida_serial_pkg;

    // Byte receiver states; the values also appear on db_estado[1:0].
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        START  = 2'd1,
        DADOS  = 2'd2,
        STOP   = 2'd3
    } byte_state_t;

    // Frame assembler states; the values also appear on db_estado[3:2].
    typedef enum logic [1:0] {
        D2   = 2'd0,
        D1   = 2'd1,
        D0   = 2'd2,
        HASH = 2'd3
    } frame_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_HASH = 8'h23;

    // True when the byte is an ASCII decimal digit.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/receptor_medida_serial_if.sv
// Byte-level link from the UART receiver to the frame assembler.
interface receptor_medida_serial_if;
    import receptor_medida_serial_pkg::*;

    logic [7:0]  dado;         // last shifted byte, stable while dado_valido is high
    logic        dado_valido;  // one-cycle pulse: byte with a good stop bit
    logic        erro_stop;    // one-cycle pulse: stop bit sampled low
    byte_state_t estado;       // current receiver state

    modport master (output dado, dado_valido, erro_stop, estado);
    modport slave  (input  dado, dado_valido, erro_stop, estado);
endinterface

// File: rtl/rx_serial_8n1.sv
// 8N1 UART byte receiver: synchronizer, start-bit check, mid-bit sampling.
module rx_serial_8n1
    import receptor_medida_serial_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     serial,
    receptor_medida_serial_if.master rx_if
);

    localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

    logic              sync1_q, sync2_q, prev_q;
    byte_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              valido_q, valido_d;
    logic              erro_q, erro_d;

    logic falling, half_bit, full_bit;

    assign falling  = prev_q & ~sync2_q;
    assign half_bit = (baud_q == BAUD_HALF);
    assign full_bit = (baud_q == BAUD_LAST);

    // State register plus synchronizer and datapath flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: synchronizer flops reset to 1 so the idle-high line never looks like a start edge.
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            state_q  <= OCIOSO;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, keeping the 2-flop chain a real chain.
            sync1_q  <= serial;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
        end
    end

    // Next-state logic for the byte receiver.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            OCIOSO: if (falling) state_d = START;
            START:  if (half_bit) state_d = sync2_q ? OCIOSO : DADOS;
            DADOS:  if (full_bit && (bit_q == 3'd7)) state_d = STOP;
            STOP:   if (full_bit) state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
    end

    // Counters, shift register and result pulses.
    always_comb begin
        baud_d   = baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        valido_d = 1'b0;
        erro_d   = 1'b0;
        case (state_q)
            OCIOSO: begin
                baud_d = '0;
                bit_d  = '0;
            end
            DADOS: begin
                if (full_bit) begin
                    baud_d  = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (full_bit) begin
                    valido_d = sync2_q;
                    erro_d   = ~sync2_q;
                end
            end
            default: ;
        endcase
        if (state_d != state_q) baud_d = '0;
    end

    assign rx_if.dado        = shift_q;
    assign rx_if.dado_valido = valido_q;
    assign rx_if.erro_stop   = erro_q;
    assign rx_if.estado      = state_q;

endmodule

// File: rtl/receptor_medida_serial.sv
// Serial measurement receiver: assembles "ddd#" frames into a 3-digit BCD value.
module receptor_medida_serial
    import receptor_medida_serial_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro_stop,
    output logic        erro_frame,
    output logic [3:0]  db_estado,
    output logic [7:0]  db_dado
);

    receptor_medida_serial_if rx_link ();

    rx_serial_8n1 #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_rx (
        .clock  (clock),
        .reset  (reset),
        .serial (serial),
        .rx_if  (rx_link.master)
    );

    frame_state_t frame_q, frame_d;
    logic [3:0]   d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic [11:0]  medida_q, medida_d;
    logic [7:0]   db_dado_q, db_dado_d;
    logic         pronto_q, pronto_d;
    logic         erro_stop_q, erro_stop_d;
    logic         erro_frame_q, erro_frame_d;

    logic [7:0] b;
    logic       b_digit;

    assign b       = rx_link.dado;
    assign b_digit = is_digit(b);

    // Frame state register and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_q      <= D2;
            d2_q         <= '0;
            d1_q         <= '0;
            d0_q         <= '0;
            medida_q     <= '0;
            db_dado_q    <= '0;
            pronto_q     <= 1'b0;
            erro_stop_q  <= 1'b0;
            erro_frame_q <= 1'b0;
        end else begin
            frame_q      <= frame_d;
            d2_q         <= d2_d;
            d1_q         <= d1_d;
            d0_q         <= d0_d;
            medida_q     <= medida_d;
            db_dado_q    <= db_dado_d;
            pronto_q     <= pronto_d;
            erro_stop_q  <= erro_stop_d;
            erro_frame_q <= erro_frame_d;
        end
    end

    // Next-state logic: digits advance, anything unexpected restarts at D2.
    always_comb begin
        frame_d = frame_q;
        if (rx_link.erro_stop) begin
            frame_d = D2;
        end else if (rx_link.dado_valido) begin
            case (frame_q)
                D2:      frame_d = b_digit ? D1 : D2;
                D1:      frame_d = b_digit ? D0 : D2;
                D0:      frame_d = b_digit ? HASH : D2;
                HASH:    frame_d = D2;
                default: frame_d = D2;
            endcase
        end
    end

    // Output logic: digit capture, measurement load and event pulses.
    always_comb begin
        d2_d         = d2_q;
        d1_d         = d1_q;
        d0_d         = d0_q;
        medida_d     = medida_q;
        db_dado_d    = db_dado_q;
        pronto_d     = 1'b0;
        erro_frame_d = 1'b0;
        erro_stop_d  = rx_link.erro_stop;
        if (rx_link.dado_valido) begin
            db_dado_d = b;
            case (frame_q)
                D2: if (b_digit) d2_d = b[3:0]; else erro_frame_d = 1'b1;
                D1: if (b_digit) d1_d = b[3:0]; else erro_frame_d = 1'b1;
                D0: if (b_digit) d0_d = b[3:0]; else erro_frame_d = 1'b1;
                HASH: begin
                    if (b == ASCII_HASH) begin
                        medida_d = {d2_q, d1_q, d0_q};
                        pronto_d = 1'b1;
                    end else begin
                        erro_frame_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign medida     = medida_q;
    assign pronto     = pronto_q;
    assign erro_stop  = erro_stop_q;
    assign erro_frame = erro_frame_q;
    assign db_dado    = db_dado_q;
    assign db_estado  = {frame_q, rx_link.estado};

endmodule

// File: tb/tb_receptor_medida_serial.sv
// Directed bench for receptor_medida_serial at 8 clocks per bit.
module tb_receptor_medida_serial;
    import receptor_medida_serial_pkg::*;

    localparam int CPB = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        serial;
    logic [11:0] medida;
    logic        pronto, erro_stop, erro_frame;
    logic [3:0]  db_estado;
    logic [7:0]  db_dado;

    int checks = 0;
    int errors = 0;

    int pronto_cnt = 0, estop_cnt = 0, eframe_cnt = 0;
    int wide_cnt = 0, overlap_cnt = 0;
    logic [11:0] pronto_log [0:15];
    logic pronto_p = 1'b0, estop_p = 1'b0, eframe_p = 1'b0;

    int p0, s0, f0;

    receptor_medida_serial_if mon_if ();

    receptor_medida_serial #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .serial     (serial),
        .medida     (medida),
        .pronto     (pronto),
        .erro_stop  (erro_stop),
        .erro_frame (erro_frame),
        .db_estado  (db_estado),
        .db_dado    (db_dado)
    );

    assign mon_if.dado        = db_dado;
    assign mon_if.dado_valido = pronto;
    assign mon_if.erro_stop   = erro_stop;
    assign mon_if.estado      = byte_state_t'(db_estado[1:0]);

    always #5 clock = ~clock;

    // Pulse monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clock) begin
        if (pronto) begin
            if (pronto_cnt < 16) pronto_log[pronto_cnt] = medida;
            pronto_cnt++;
        end
        if (erro_stop)  estop_cnt++;
        if (erro_frame) eframe_cnt++;
        if ((pronto && pronto_p) || (erro_stop && estop_p) || (erro_frame && eframe_p)) wide_cnt++;
        if ((int'(pronto) + int'(erro_stop) + int'(erro_frame)) > 1) overlap_cnt++;
        pronto_p = pronto;
        estop_p  = erro_stop;
        eframe_p = erro_frame;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8N1 byte starting at a falling edge, followed by gap idle bits.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap_bits);
        serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            serial = b[i];
            repeat (CPB) @(negedge clock);
        end
        serial = stop_bit;
        repeat (CPB) @(negedge clock);
        serial = 1'b1;
        repeat (CPB * gap_bits) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input int gap_bits);
        send_byte(a, 1'b1, gap_bits);
        send_byte(b, 1'b1, gap_bits);
        send_byte(c, 1'b1, gap_bits);
        send_byte(d, 1'b1, gap_bits);
    endtask

    initial begin
        reset  = 1'b1;
        serial = 1'b1;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_medida", 32'(medida), 32'h000);
        check("rst_pronto", 32'(pronto), 32'h0);
        check("rst_estop", 32'(erro_stop), 32'h0);
        check("rst_eframe", 32'(erro_frame), 32'h0);
        check("rst_estado", 32'(db_estado), 32'h0);
        check("rst_dado", 32'(mon_if.dado), 32'h00);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // "123#"
        p0 = pronto_cnt; s0 = estop_cnt; f0 = eframe_cnt;
        send_frame(8'h31, 8'h32, 8'h33, 8'h23, 2);
        check("f123_medida", 32'(medida), 32'h123);
        check("f123_pronto", 32'(pronto_cnt - p0), 32'd1);
        check("f123_estop", 32'(estop_cnt - s0), 32'd0);
        check("f123_eframe", 32'(eframe_cnt - f0), 32'd0);
        check("f123_dado", 32'(db_dado), 32'h23);
        check("f123_estado", 32'(db_estado), 32'h0);

        // "45A#": error on 'A', then '#' arrives in D2 and is also rejected
        p0 = pronto_cnt; s0 = estop_cnt; f0 = eframe_cnt;
        send_frame(8'h34, 8'h35, 8'h41, 8'h23, 2);
        check("f45A_medida", 32'(medida), 32'h123);
        check("f45A_pronto", 32'(pronto_cnt - p0), 32'd0);
        check("f45A_eframe", 32'(eframe_cnt - f0), 32'd2);
        check("f45A_estop", 32'(estop_cnt - s0), 32'd0);

        // "067#"
        p0 = pronto_cnt;
        send_frame(8'h30, 8'h36, 8'h37, 8'h23, 2);
        check("f067_medida", 32'(medida), 32'h067);
        check("f067_pronto", 32'(pronto_cnt - p0), 32'd1);

        // Start of a frame "9", then 0x31 with a bad stop bit
        p0 = pronto_cnt; s0 = estop_cnt; f0 = eframe_cnt;
        send_byte(8'h39, 1'b1, 2);
        send_byte(8'h31, 1'b0, 2);
        check("stop_estop", 32'(estop_cnt - s0), 32'd1);
        check("stop_pronto", 32'(pronto_cnt - p0), 32'd0);
        check("stop_eframe", 32'(eframe_cnt - f0), 32'd0);
        check("stop_medida", 32'(medida), 32'h067);
        check("stop_dado", 32'(db_dado), 32'h39);
        check("stop_frame_state", 32'(db_estado[3:2]), 32'(D2));

        // "999#" after the stop error
        p0 = pronto_cnt;
        send_frame(8'h39, 8'h39, 8'h39, 8'h23, 2);
        check("f999_medida", 32'(medida), 32'h999);
        check("f999_pronto", 32'(pronto_cnt - p0), 32'd1);

        // Three-clock low glitch on the idle line
        p0 = pronto_cnt; s0 = estop_cnt; f0 = eframe_cnt;
        serial = 1'b0;
        repeat (3) @(negedge clock);
        serial = 1'b1;
        repeat (4 * CPB) @(negedge clock);
        check("glitch_dado", 32'(db_dado), 32'h23);
        check("glitch_pulses", 32'((pronto_cnt - p0) + (estop_cnt - s0) + (eframe_cnt - f0)), 32'd0);
        check("glitch_estado", 32'(db_estado), 32'h0);
        check("glitch_medida", 32'(medida), 32'h999);

        // Reset pulse during the data bits of "7"; the line is then left idle
        serial = 1'b0;
        repeat (CPB) @(negedge clock);
        serial = 1'b1;
        repeat (CPB / 2) @(negedge clock);
        check("mid_estado_dados", 32'(db_estado[1:0]), 32'(DADOS));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mrst_medida", 32'(medida), 32'h000);
        check("mrst_dado", 32'(db_dado), 32'h00);
        check("mrst_estado", 32'(db_estado), 32'h0);
        check("mrst_pulses", 32'({pronto, erro_stop, erro_frame}), 32'h0);
        repeat (2 * CPB) @(negedge clock);

        // "045#" after reset
        p0 = pronto_cnt; f0 = eframe_cnt;
        send_frame(8'h30, 8'h34, 8'h35, 8'h23, 2);
        check("f045_medida", 32'(medida), 32'h045);
        check("f045_pronto", 32'(pronto_cnt - p0), 32'd1);
        check("f045_eframe", 32'(eframe_cnt - f0), 32'd0);

        // "100#" "200#" back to back, no idle time between any bytes
        p0 = pronto_cnt;
        send_frame(8'h31, 8'h30, 8'h30, 8'h23, 0);
        send_frame(8'h32, 8'h30, 8'h30, 8'h23, 0);
        serial = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check("b2b_pronto", 32'(pronto_cnt - p0), 32'd2);
        check("b2b_first", 32'(pronto_log[p0 % 16]), 32'h100);
        check("b2b_second", 32'(pronto_log[(p0 + 1) % 16]), 32'h200);
        check("b2b_medida", 32'(medida), 32'h200);

        // Pulse shape over the whole run
        check("pulse_width", 32'(wide_cnt), 32'd0);
        check("pulse_overlap", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/receptor_medida_serial.md
RECEPTOR_MEDIDA_SERIAL -- requirements
Module: receptor_medida_serial

Interface
REQ-001 The parameter list SHALL be: CLOCKS_PER_BIT, default 434, clocks per UART bit (115200 baud at 50 MHz).
REQ-002 The port list SHALL begin with: clock  input  1  single system clock; all logic on its rising edge.
REQ-003 The next port SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 The next port SHALL be: serial  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-005 The next port SHALL be: medida  output  12  last valid measurement, 3 BCD digits, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 The next port SHALL be: pronto  output  1  one-cycle pulse when medida has been updated.
REQ-007 The next port SHALL be: erro_stop  output  1  one-cycle pulse on a stop-bit error.
REQ-008 The next port SHALL be: erro_frame  output  1  one-cycle pulse on a malformed frame.
REQ-009 The last ports SHALL be: db_estado  output  4  receiver state code; db_dado  output  8  last byte received.

Function
REQ-010 serial SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-011 Byte receiver FSM states SHALL be: OCIOSO, START, DADOS, STOP.
- OCIOSO: a synchronized 1->0 transition moves to START.
REQ-012 In START, after CLOCKS_PER_BIT/2 clocks the line SHALL be resampled.
- 0: go to DADOS.
- 1: glitch; return to OCIOSO with no outputs.
REQ-013 In DADOS, 8 bits SHALL be sampled every CLOCKS_PER_BIT clocks at mid-bit and shifted in LSB first.
REQ-014 In STOP, the line SHALL be sampled CLOCKS_PER_BIT clocks after the last data bit.
- 1: byte valid; byte goes to db_dado and to the frame assembler.
- 0: erro_stop pulses; byte is discarded; frame assembler returns to D2.
- Either case: return to OCIOSO.
REQ-015 The bit counter SHALL be 3 bits. The baud counter SHALL be wide enough for CLOCKS_PER_BIT-1 and SHALL clear on every state change.
REQ-016 The frame format SHALL be 4 bytes: ASCII digit, digit, digit, '#' (0x23).
- Frame assembler states: D2, D1, D0, HASH.
REQ-017 In D2/D1/D0, a byte 0x30-0x39 SHALL store its low nibble and advance the state.
- Any other byte (including '#') SHALL pulse erro_frame and return to D2.
REQ-018 In HASH:
- 0x23: medida loads {d2,d1,d0} and pronto pulses, both on the clock after the stop-bit sample.
- Any other byte: erro_frame pulses and the state returns to D2; medida is unchanged.
REQ-019 medida SHALL hold its value between valid frames and through every error.
REQ-020 At most one of pronto, erro_stop and erro_frame SHALL be high in any cycle. Each SHALL be exactly 1 cycle wide.
REQ-021 Back-to-back bytes with zero idle time after the stop bit SHALL be received correctly. The next falling edge is detected from OCIOSO on the cycle after STOP.
REQ-022 db_estado codes SHALL be: OCIOSO=0, START=1, DADOS=2, STOP=3. Bits [3:2] SHALL give the frame assembler state (D2=0, D1=1, D0=2, HASH=3).

Reset
REQ-023 On reset the following SHALL apply:
- Both FSMs go to OCIOSO/D2.
- All counters, medida, db_dado, pronto, erro_stop and erro_frame go to 0.
- Synchronizer flops go to 1 (idle).
REQ-024 Reset asserted mid-byte or mid-frame SHALL discard the partial data. Reception SHALL restart only at a falling edge seen after reset is released.

Structure
REQ-025 A shared package SHALL hold:
- the byte-FSM and frame-FSM state encodings;
- the constants ASCII_ZERO=0x30, ASCII_NINE=0x39, ASCII_HASH=0x23.
REQ-026 One sub-module, rx_serial_8n1, SHALL implement REQ-010 to REQ-015. It outputs a byte plus one-cycle dado_valido and erro_stop pulses.
- The top level SHALL contain only the frame assembler and the output registers.

Verification
REQ-027 The bench SHALL use CLOCKS_PER_BIT=8 and cover all of the following:
- Bytes "1","2","3","#" -> medida=0x123, pronto high for exactly 1 cycle, no error pulses.
- "4","5","A","#" after 0x123 -> erro_frame on byte 'A' -> medida stays 0x123, no pronto; a following "067#" -> medida=0x067.
- 0x31 sent with stop bit 0 -> erro_stop 1 cycle -> the next "999#" yields 0x999.
- Low glitch of 3 clocks on idle line -> no byte, db_dado unchanged, no pulses.
- Reset held 1 cycle during the data bits of "7" -> all outputs 0 -> then "045#" -> medida=0x045.
- Frames "100#""200#" with zero idle gap -> two pronto pulses; medida=0x100 then 0x200.
